// File: rtl/rf_addr_reader.sv
// Streams a snapshot of the address register file one entry per cycle over valid/ready,
// converting each {h, w, k} entry to a linear feature-map SRAM address.
module rf_addr_reader #(
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned FW     = 7,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned CH     = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [DEPTH-1:0][2:0][FW-1:0]     i_RF,
    input  logic [LEN_W-1:0]                  i_length,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [FW-1:0]                     o_h,
    output logic [FW-1:0]                     o_w,
    output logic [FW-1:0]                     o_k,
    output logic [ADDR_W-1:0]                 o_addr,
    output logic [LEN_W-1:0]                  o_idx,
    output logic                              o_last,
    output logic                              o_busy,
    output logic                              o_finish
);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e                          state_q, state_d;
    logic [DEPTH-1:0][2:0][FW-1:0]   rf_q, rf_d;
    logic [LEN_W-1:0]                len_q, len_d;
    logic [LEN_W-1:0]                idx_q, idx_d;
    logic                            valid_q, valid_d;
    logic                            last_q, last_d;
    logic                            busy_q, busy_d;
    logic                            finish_q, finish_d;
    logic [FW-1:0]                   h_q, h_d, w_q, w_d, k_q, k_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [LEN_W-1:0]                eff_len;
    logic [2:0][FW-1:0]              entry;
    logic                            load;

    // Full-width unsigned arithmetic, truncated to the address width at the end.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [FW-1:0] h,
                                                   input logic [FW-1:0] w,
                                                   input logic [FW-1:0] k);
        logic [31:0] full;
        full = ((32'(h) * 32'(IMG_W)) + 32'(w)) * 32'(CH) + 32'(k);
        return full[ADDR_W-1:0];
    endfunction

    assign eff_len = (32'(i_length) > DEPTH) ? LEN_W'(DEPTH) : i_length;

    always_comb begin
        state_d  = state_q;
        rf_d     = rf_q;
        len_d    = len_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        finish_d = 1'b0;
        h_d      = h_q;
        w_d      = w_q;
        k_d      = k_q;
        addr_d   = addr_q;
        load     = 1'b0;
        entry    = '0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (eff_len != '0) begin
                        rf_d    = i_RF;
                        len_d   = eff_len;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        load    = 1'b1;
                        state_d = StStream;
                    end else begin
                        finish_d = 1'b1;
                    end
                end
            end
            StStream: begin
                if (valid_q && i_ready) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        valid_d  = 1'b0;
                        finish_d = 1'b1;
                        state_d  = StDone;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // rf_d already holds the fresh snapshot on a start, so one path covers both cases.
        if (load) begin
            entry  = rf_d[idx_d];
            h_d    = entry[0];
            w_d    = entry[1];
            k_d    = entry[2];
            addr_d = lin_addr(entry[0], entry[1], entry[2]);
        end

        last_d = valid_d && (idx_d == len_d - LEN_W'(1));
        busy_d = (state_d == StStream);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            rf_q     <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            h_q      <= '0;
            w_q      <= '0;
            k_q      <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rf_q     <= rf_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            h_q      <= h_d;
            w_q      <= w_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_h      = h_q;
    assign o_w      = w_q;
    assign o_k      = k_q;
    assign o_addr   = addr_q;
    assign o_idx    = idx_q;
    assign o_last   = last_q;
    assign o_busy   = busy_q;
    assign o_finish = finish_q;

endmodule

// File: tb/tb_rf_addr_reader.sv
// Directed bench for rf_addr_reader: table of entries with hand-computed addresses,
// streamed under several lengths, backpressure, restart and mid-stream reset.
module tb_rf_addr_reader;

    localparam int DEPTH = 10;
    localparam int FW = 7;
    localparam int LEN_W = 4;
    localparam int ADDR_W = 16;

    logic                          i_clk = 1'b0;
    logic                          i_rst = 1'b1;
    logic                          i_start = 1'b0;
    logic [DEPTH-1:0][2:0][FW-1:0] i_RF = '0;
    logic [LEN_W-1:0]              i_length = '0;
    logic                          i_ready = 1'b1;
    logic                          o_valid, o_last, o_busy, o_finish;
    logic [FW-1:0]                 o_h, o_w, o_k;
    logic [ADDR_W-1:0]             o_addr;
    logic [LEN_W-1:0]              o_idx;

    rf_addr_reader dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_RF     (i_RF),
        .i_length (i_length),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_h      (o_h),
        .o_w      (o_w),
        .o_k      (o_k),
        .o_addr   (o_addr),
        .o_idx    (o_idx),
        .o_last   (o_last),
        .o_busy   (o_busy),
        .o_finish (o_finish)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int h;
        int w;
        int k;
        int addr;
    } vec_t;

    vec_t vec [10];
    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int fin_cnt = 0;

    always @(posedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) hs_cnt <= hs_cnt + 1;
            if (o_finish) fin_cnt <= fin_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic load_rf(input int base, input int n);
        i_RF = '0;
        for (int j = 0; j < n; j++) begin
            i_RF[j][0] = FW'(vec[base + j].h);
            i_RF[j][1] = FW'(vec[base + j].w);
            i_RF[j][2] = FW'(vec[base + j].k);
        end
    endtask

    task automatic pulse_start(input int len);
        i_length = LEN_W'(len);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic check_entry(input int base, input int i, input int n);
        check("valid", 64'(o_valid), 64'(1));
        check("busy", 64'(o_busy), 64'(1));
        check("idx", 64'(o_idx), 64'(i));
        check("hwk", {o_h, o_w, o_k},
              {FW'(vec[base + i].h), FW'(vec[base + i].w), FW'(vec[base + i].k)});
        check("addr", 64'(o_addr), 64'(vec[base + i].addr));
        check("last", 64'(o_last), 64'(i == n - 1));
    endtask

    // Called one negedge after the start pulse; walks the whole stream and the finish pulse.
    task automatic stream_check(input int base, input int n, input int stall_at,
                                input int stall_len);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                i_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_entry(base, i, n);
                    @(negedge i_clk);
                end
                i_ready = 1'b1;
            end
            check_entry(base, i, n);
            @(negedge i_clk);
        end
        check("end_valid", 64'(o_valid), 64'(0));
        check("end_busy", 64'(o_busy), 64'(0));
        check("finish", 64'(o_finish), 64'(1));
        @(negedge i_clk);
        check("finish_pulse", 64'(o_finish), 64'(0));
    endtask

    initial begin
        int hs0, fin0;
        vec[0] = '{10, 11, 0, 20832};
        vec[1] = '{11, 10, 1, 22849};
        vec[2] = '{127, 127, 31, 2047};
        vec[3] = '{0, 0, 0, 0};
        vec[4] = '{1, 2, 3, 2115};
        vec[5] = '{5, 63, 7, 12263};
        vec[6] = '{63, 0, 31, 63519};
        vec[7] = '{2, 5, 9, 4265};
        vec[8] = '{100, 1, 0, 8224};
        vec[9] = '{7, 7, 7, 14567};

        repeat (2) @(negedge i_clk);
        check("reset_outs", {o_valid, o_busy, o_finish, o_last, o_addr, o_idx, o_h, o_w, o_k},
              '0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("idle_outs", {o_valid, o_busy, o_finish}, 3'b000);

        // Basic two-entry stream.
        load_rf(0, 2);
        pulse_start(2);
        stream_check(0, 2, -1, 0);

        // Backpressure on entry 1.
        hs0 = hs_cnt;
        fin0 = fin_cnt;
        load_rf(0, 3);
        pulse_start(3);
        stream_check(0, 3, 1, 4);
        check("bp_handshakes", 64'(hs_cnt - hs0), 64'(3));
        check("bp_finishes", 64'(fin_cnt - fin0), 64'(1));

        // Zero length: finish only.
        pulse_start(0);
        check("l0_valid", 64'(o_valid), 64'(0));
        check("l0_finish", 64'(o_finish), 64'(1));
        @(negedge i_clk);
        check("l0_finish_pulse", {o_finish, o_valid}, 2'b00);

        // Length clamp.
        load_rf(0, 10);
        pulse_start(15);
        stream_check(0, 10, -1, 0);

        // Snapshot isolation: i_RF scrambled and i_start held through STREAM and DONE.
        load_rf(0, 4);
        pulse_start(4);
        i_RF = '1;
        i_length = LEN_W'(2);
        i_start = 1'b1;
        stream_check(0, 4, 2, 2);
        i_start = 1'b0;
        @(negedge i_clk);
        check("restart_ignored", {o_valid, o_busy}, 2'b00);

        // New data after finish.
        load_rf(4, 6);
        pulse_start(6);
        stream_check(4, 6, -1, 0);

        // Async reset during entry 1 of a 5-entry stream.
        load_rf(0, 5);
        pulse_start(5);
        check_entry(0, 0, 5);
        @(negedge i_clk);
        check_entry(0, 1, 5);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_outs",
              {o_valid, o_busy, o_finish, o_last, o_addr, o_idx, o_h, o_w, o_k}, '0);
        @(negedge i_clk);
        i_rst = 1'b0;
        fin0 = fin_cnt;
        repeat (3) @(negedge i_clk);
        check("rst_no_finish", 64'(fin_cnt - fin0), 64'(0));
        check("rst_idle", {o_valid, o_busy}, 2'b00);
        pulse_start(5);
        stream_check(0, 5, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
